// File: rtl/track_selector.sv
// track_selector: once per frame, scans NUM_CH tracker channels and latches one target.
// Optional macro SEL_HYST_EN adds two-frame switching hysteresis on the selected channel.
module track_selector #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int CW         = 12,
  parameter int PW         = 10,
  parameter int YW         = 10,
  parameter int LATCH_LINE = 480,
  parameter int MISS_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [YW-1:0]          current_pos_y,
  input  logic [1:0]             mode,
  input  logic [CH_W-1:0]        fix_ch,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic [NUM_CH-1:0]      ch_dir,
  input  logic [NUM_CH*CW-1:0]   ch_centre_x,
  input  logic [NUM_CH*CW-1:0]   ch_centre_y,
  input  logic [NUM_CH*PW-1:0]   ch_angle_x,
  input  logic [NUM_CH*PW-1:0]   ch_angle_y,
  input  logic [NUM_CH*8*PW-1:0] ch_box,
  output logic [CW-1:0]          centre_pos_x_rs232,
  output logic [CW-1:0]          centre_pos_y_rs232,
  output logic [PW-1:0]          angle_x_rs232,
  output logic [PW-1:0]          angle_y_rs232,
  output logic                   chieu_xoay_rs232,
  output logic [8*PW-1:0]        box_vga,
  output logic [CH_W-1:0]        sel_ch,
  output logic                   track_lost,
  output logic                   upd_stb
);
  localparam int              MW       = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0]   MISS_MAX = MW'(MISS_LIMIT);
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [YW-1:0]   LATCH_Y  = YW'(LATCH_LINE);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v >= MISS_MAX) ? v : v + MW'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q;
  logic [YW-1:0]     y_prev_q;
  logic [1:0]        mode_q;
  logic [CH_W-1:0]   fix_q;
  logic              best_found_q;
  logic [CH_W-1:0]   best_idx_q;
  logic              best_dir0_q;
  logic [CW:0]       best_dist_q;
  logic [CW-1:0]     best_cx_q, best_cy_q;
  logic [PW-1:0]     best_ax_q, best_ay_q;
  logic              best_dir_q;
  logic [8*PW-1:0]   best_box_q;
  logic [MW-1:0]     miss_q;
  logic              have_prev_q;

  logic [CW-1:0]     cx_a  [NUM_CH];
  logic [CW-1:0]     cy_a  [NUM_CH];
  logic [PW-1:0]     ax_a  [NUM_CH];
  logic [PW-1:0]     ay_a  [NUM_CH];
  logic [8*PW-1:0]   box_a [NUM_CH];

  logic              trig;
  logic [1:0]        eff_mode;
  logic [CW:0]       cand_dist;
  logic              take;
  logic [CH_W-1:0]   ld_idx;
  logic [CW-1:0]     ld_cx, ld_cy;
  logic [PW-1:0]     ld_ax, ld_ay;
  logic              ld_dir;
  logic [8*PW-1:0]   ld_box;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cx_a[i]  = ch_centre_x[i*CW +: CW];
      cy_a[i]  = ch_centre_y[i*CW +: CW];
      ax_a[i]  = ch_angle_x[i*PW +: PW];
      ay_a[i]  = ch_angle_y[i*PW +: PW];
      box_a[i] = ch_box[i*8*PW +: 8*PW];
    end
  end

  // Edge-detected line trigger: one scan per frame however long the line lasts
  assign trig = (current_pos_y == LATCH_Y) && (y_prev_q != LATCH_Y);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (trig) state_d = S_SCAN;
      S_SCAN:   if (idx_q == LAST_IDX) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      y_prev_q     <= '0;
      mode_q       <= '0;
      fix_q        <= '0;
      best_found_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_prev_q <= current_pos_y;
      if (state_q == S_IDLE && trig) begin
        idx_q        <= '0;
        mode_q       <= mode;
        fix_q        <= fix_ch;
        best_found_q <= 1'b0;
      end else if (state_q == S_SCAN) begin
        idx_q <= idx_q + CH_W'(1);
        if (take) best_found_q <= 1'b1;
      end
    end
  end

  // Scan stage: compare channel idx_q against the running best
  always_comb begin
    eff_mode = mode_q;
    if (mode_q == 2'd3 || (mode_q == 2'd1 && !have_prev_q)) eff_mode = 2'd0;
    cand_dist = abs_diff(cx_a[idx_q], centre_pos_x_rs232) + abs_diff(cy_a[idx_q], centre_pos_y_rs232);
    take = 1'b0;
    case (eff_mode)
      2'd2:    take = ch_valid[idx_q] && (idx_q == fix_q);
      2'd1:    take = ch_valid[idx_q] && (!best_found_q || cand_dist < best_dist_q);
      default: take = ch_valid[idx_q] && (!best_found_q || (!best_dir0_q && !ch_dir[idx_q]));
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_SCAN && take) begin
      best_idx_q  <= idx_q;
      best_dir0_q <= ~ch_dir[idx_q];
      best_dist_q <= cand_dist;
      best_cx_q   <= cx_a[idx_q];
      best_cy_q   <= cy_a[idx_q];
      best_ax_q   <= ax_a[idx_q];
      best_ay_q   <= ay_a[idx_q];
      best_dir_q  <= ch_dir[idx_q];
      best_box_q  <= box_a[idx_q];
    end
  end

`ifdef SEL_HYST_EN
  logic            pend_vld_q, pend_vld_d;
  logic [CH_W-1:0] pend_idx_q, pend_idx_d;
  logic            cur_valid_q;
  logic [CW-1:0]   cur_cx_q, cur_cy_q;
  logic [PW-1:0]   cur_ax_q, cur_ay_q;
  logic            cur_dir_q;
  logic [8*PW-1:0] cur_box_q;

  // Snapshot of the currently selected channel, used to hold it against a one-frame challenger
  always_ff @(posedge clk) begin
    if (state_q == S_SCAN && idx_q == sel_ch) begin
      cur_valid_q <= ch_valid[idx_q];
      cur_cx_q    <= cx_a[idx_q];
      cur_cy_q    <= cy_a[idx_q];
      cur_ax_q    <= ax_a[idx_q];
      cur_ay_q    <= ay_a[idx_q];
      cur_dir_q   <= ch_dir[idx_q];
      cur_box_q   <= box_a[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
    end else if (state_q == S_COMMIT) begin
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
    end
  end
`endif

  always_comb begin
    ld_idx = best_idx_q;
    ld_cx  = best_cx_q;
    ld_cy  = best_cy_q;
    ld_ax  = best_ax_q;
    ld_ay  = best_ay_q;
    ld_dir = best_dir_q;
    ld_box = best_box_q;
`ifdef SEL_HYST_EN
    pend_vld_d = 1'b0;
    pend_idx_d = pend_idx_q;
    if (best_found_q && have_prev_q && best_idx_q != sel_ch &&
        !(pend_vld_q && pend_idx_q == best_idx_q) && cur_valid_q) begin
      pend_vld_d = 1'b1;
      pend_idx_d = best_idx_q;
      ld_idx     = sel_ch;
      ld_cx      = cur_cx_q;
      ld_cy      = cur_cy_q;
      ld_ax      = cur_ax_q;
      ld_ay      = cur_ay_q;
      ld_dir     = cur_dir_q;
      ld_box     = cur_box_q;
    end
`endif
  end

  // Commit stage: outputs, miss counter and strobe change only here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      centre_pos_x_rs232 <= '0;
      centre_pos_y_rs232 <= '0;
      angle_x_rs232      <= '0;
      angle_y_rs232      <= '0;
      chieu_xoay_rs232   <= 1'b0;
      box_vga            <= '0;
      sel_ch             <= '0;
      track_lost         <= 1'b1;
      upd_stb            <= 1'b0;
      miss_q             <= '0;
      have_prev_q        <= 1'b0;
    end else begin
      upd_stb <= 1'b0;
      if (state_q == S_COMMIT) begin
        if (best_found_q) begin
          centre_pos_x_rs232 <= ld_cx;
          centre_pos_y_rs232 <= ld_cy;
          angle_x_rs232      <= ld_ax;
          angle_y_rs232      <= ld_ay;
          chieu_xoay_rs232   <= ld_dir;
          box_vga            <= ld_box;
          sel_ch             <= ld_idx;
          miss_q             <= '0;
          track_lost         <= 1'b0;
          have_prev_q        <= 1'b1;
          upd_stb            <= 1'b1;
        end else if (miss_q != MISS_MAX) begin
          miss_q <= sat_inc(miss_q);
          if (sat_inc(miss_q) == MISS_MAX) begin
            centre_pos_x_rs232 <= '0;
            centre_pos_y_rs232 <= '0;
            angle_x_rs232      <= '0;
            angle_y_rs232      <= '0;
            chieu_xoay_rs232   <= 1'b0;
            box_vga            <= '0;
            track_lost         <= 1'b1;
            have_prev_q        <= 1'b0;
            upd_stb            <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_track_selector.sv
// Randomised bench for track_selector against a frame-level selection model.
module tb_track_selector;
  localparam int N   = 4;
  localparam int CHW = 2;
  localparam int CW  = 12;
  localparam int PW  = 10;
  localparam int YW  = 10;
  localparam int LL  = 480;
  localparam int ML  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [YW-1:0]     y, y2;
  logic [1:0]        mode;
  logic [CHW-1:0]    fix_ch;
  logic [N-1:0]      ch_valid, ch_dir;
  logic [N*CW-1:0]   ch_cx, ch_cy;
  logic [N*PW-1:0]   ch_ax, ch_ay;
  logic [N*8*PW-1:0] ch_box;
  logic [CW-1:0]     o_cx, o_cy;
  logic [PW-1:0]     o_ax, o_ay;
  logic              o_dir;
  logic [8*PW-1:0]   o_box;
  logic [CHW-1:0]    o_sel;
  logic              o_lost, o_upd;

  logic [1:0]        v2, d2;
  logic [CW-1:0]     o2_cx, o2_cy;
  logic [PW-1:0]     o2_ax, o2_ay;
  logic              o2_dir;
  logic [8*PW-1:0]   o2_box;
  logic              o2_sel, o2_lost, o2_upd;

  track_selector #(.NUM_CH(N), .CH_W(CHW), .CW(CW), .PW(PW), .YW(YW), .LATCH_LINE(LL), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .current_pos_y(y), .mode(mode), .fix_ch(fix_ch),
    .ch_valid(ch_valid), .ch_dir(ch_dir), .ch_centre_x(ch_cx), .ch_centre_y(ch_cy),
    .ch_angle_x(ch_ax), .ch_angle_y(ch_ay), .ch_box(ch_box),
    .centre_pos_x_rs232(o_cx), .centre_pos_y_rs232(o_cy), .angle_x_rs232(o_ax), .angle_y_rs232(o_ay),
    .chieu_xoay_rs232(o_dir), .box_vga(o_box), .sel_ch(o_sel), .track_lost(o_lost), .upd_stb(o_upd));

  track_selector #(.NUM_CH(2), .CH_W(1), .CW(CW), .PW(PW), .YW(YW), .LATCH_LINE(LL), .MISS_LIMIT(ML)) dut2 (
    .clk(clk), .rst_n(rst_n), .current_pos_y(y2), .mode(2'd0), .fix_ch(1'b0),
    .ch_valid(v2), .ch_dir(d2), .ch_centre_x(ch_cx[2*CW-1:0]), .ch_centre_y(ch_cy[2*CW-1:0]),
    .ch_angle_x(ch_ax[2*PW-1:0]), .ch_angle_y(ch_ay[2*PW-1:0]), .ch_box(ch_box[2*8*PW-1:0]),
    .centre_pos_x_rs232(o2_cx), .centre_pos_y_rs232(o2_cy), .angle_x_rs232(o2_ax), .angle_y_rs232(o2_ay),
    .chieu_xoay_rs232(o2_dir), .box_vga(o2_box), .sel_ch(o2_sel), .track_lost(o2_lost), .upd_stb(o2_upd));

  logic [CW-1:0]   t_cx [N];
  logic [CW-1:0]   t_cy [N];
  logic [PW-1:0]   t_ax [N];
  logic [PW-1:0]   t_ay [N];
  logic [8*PW-1:0] t_box[N];

  logic [CW-1:0]   m_cx, m_cy;
  logic [PW-1:0]   m_ax, m_ay;
  logic            m_dir;
  logic [8*PW-1:0] m_box;
  int              m_sel, m_miss, m_pidx;
  bit              m_have, m_lost, m_pvld;

  int total = 0;
  int bad   = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_cx = '0; m_cy = '0; m_ax = '0; m_ay = '0; m_dir = 1'b0; m_box = '0;
    m_sel = 0; m_miss = 0; m_pidx = 0; m_have = 0; m_lost = 1; m_pvld = 0;
  endtask

  task automatic randomize_ch();
    logic [95:0] r;
    for (int i = 0; i < N; i++) begin
      t_cx[i] = CW'($urandom);
      t_cy[i] = CW'($urandom);
      t_ax[i] = PW'($urandom);
      t_ay[i] = PW'($urandom);
      r = {$urandom, $urandom, $urandom};
      t_box[i] = r[8*PW-1:0];
    end
  endtask

  task automatic drive_ch();
    for (int i = 0; i < N; i++) begin
      ch_cx[i*CW +: CW]       = t_cx[i];
      ch_cy[i*CW +: CW]       = t_cy[i];
      ch_ax[i*PW +: PW]       = t_ax[i];
      ch_ay[i*PW +: PW]       = t_ay[i];
      ch_box[i*8*PW +: 8*PW]  = t_box[i];
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Frame-level selection rule; returns -1 when no channel qualifies
  function automatic int ref_winner();
    int m, w, bd, d;
    m = (mode == 2'd3) ? 0 : int'(mode);
    if (m == 1 && !m_have) m = 0;
    if (m == 2) return ch_valid[fix_ch] ? int'(fix_ch) : -1;
    w = -1; bd = 0;
    if (m == 1) begin
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i]) begin
          d = iabs(int'(t_cx[i]) - int'(m_cx)) + iabs(int'(t_cy[i]) - int'(m_cy));
          if (w < 0 || d < bd) begin w = i; bd = d; end
        end
      end
      return w;
    end
    for (int i = 0; i < N; i++) if (ch_valid[i] && !ch_dir[i]) return i;
    for (int i = 0; i < N; i++) if (ch_valid[i]) return i;
    return -1;
  endfunction

  task automatic ref_commit(output bit exp_upd);
    int w;
    w = ref_winner();
    exp_upd = 0;
`ifdef SEL_HYST_EN
    if (w >= 0 && m_have && w != m_sel) begin
      if (m_pvld && m_pidx == w) m_pvld = 0;
      else if (ch_valid[m_sel]) begin m_pvld = 1; m_pidx = w; w = m_sel; end
      else m_pvld = 0;
    end else m_pvld = 0;
`endif
    if (w >= 0) begin
      m_cx = t_cx[w]; m_cy = t_cy[w]; m_ax = t_ax[w]; m_ay = t_ay[w];
      m_dir = ch_dir[w]; m_box = t_box[w]; m_sel = w;
      m_miss = 0; m_lost = 0; m_have = 1; exp_upd = 1;
    end else if (m_miss < ML) begin
      m_miss++;
      if (m_miss == ML) begin
        m_cx = '0; m_cy = '0; m_ax = '0; m_ay = '0; m_dir = 1'b0; m_box = '0;
        m_lost = 1; m_have = 0; exp_upd = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; y = '0; y2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // One trigger line; checks strobe timing and all outputs against the model
  task automatic run_frame(input string nm);
    bit eu;
    int pulses, at;
    pulses = 0; at = -1;
    drive_ch();
    @(posedge clk); #1;
    y = YW'(LL);
    for (int c = 1; c <= N + 6; c++) begin
      @(posedge clk); #1;
      if (c == 3) y = '0;
      if (o_upd) begin pulses++; at = c; end
    end
    ref_commit(eu);
    total++;
    if (eu ? (pulses != 1 || at != N + 2) : (pulses != 0)) begin
      bad++;
      $display("FAIL %s upd_stb: pulses=%0d at cycle %0d, required pulses=%0d at cycle %0d", nm, pulses, at, eu, N + 2);
    end
    total++;
    if (o_sel !== CHW'(m_sel)) begin bad++; $display("FAIL %s sel_ch: got %0d want %0d", nm, o_sel, m_sel); end
    total++;
    if ({o_cx, o_cy} !== {m_cx, m_cy}) begin
      bad++; $display("FAIL %s centre: got (%0d,%0d) want (%0d,%0d)", nm, o_cx, o_cy, m_cx, m_cy);
    end
    total++;
    if ({o_ax, o_ay, o_dir} !== {m_ax, m_ay, m_dir}) begin
      bad++; $display("FAIL %s angle/dir: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", nm, o_ax, o_ay, o_dir, m_ax, m_ay, m_dir);
    end
    total++;
    if (o_box !== m_box) begin bad++; $display("FAIL %s box: got %h want %h", nm, o_box, m_box); end
    total++;
    if (o_lost !== m_lost) begin bad++; $display("FAIL %s track_lost: got %0d want %0d", nm, o_lost, m_lost); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_cx, o_cy, o_ax, o_ay, o_dir, o_box, o_sel} !== '0) begin
      bad++; $display("FAIL reset outputs: got cx=%0d cy=%0d sel=%0d box=%h want all 0", o_cx, o_cy, o_sel, o_box);
    end
    total++;
    if (o_lost !== 1'b1 || o_upd !== 1'b0) begin
      bad++; $display("FAIL reset flags: got lost=%0d upd=%0d want lost=1 upd=0", o_lost, o_upd);
    end
    total++;
    if (o2_lost !== 1'b1 || o2_sel !== 1'b0) begin
      bad++; $display("FAIL reset dut2: got lost=%0d sel=%0d want 1/0", o2_lost, o2_sel);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_mode0();
    do_reset();
    randomize_ch();
    mode = 2'd0; ch_valid = 4'b1111; ch_dir = 4'b0011;
    run_frame("m0_dir");
    total++;
    if (o_sel !== 2'd2 || o_cx !== t_cx[2] || o_box !== t_box[2]) begin
      bad++; $display("FAIL m0_fixed: got sel=%0d cx=%0d want sel=2 cx=%0d", o_sel, o_cx, t_cx[2]);
    end
    for (int k = 0; k < 6; k++) begin
      randomize_ch();
      mode = (k[0]) ? 2'd3 : 2'd0;
      ch_valid = N'($urandom); ch_dir = N'($urandom);
      run_frame("m0_rand");
    end
  endtask

  task automatic legacy_frame(input logic [1:0] v, input logic [1:0] d, input int want);
    int pulses, at;
    pulses = 0; at = -1;
    v2 = v; d2 = d;
    randomize_ch();
    drive_ch();
    @(posedge clk); #1;
    y2 = YW'(LL);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 3) y2 = '0;
      if (o2_upd) begin pulses++; at = c; end
    end
    total++;
    if (pulses != 1 || at != 4) begin
      bad++; $display("FAIL legacy upd_stb: pulses=%0d at %0d want 1 at 4", pulses, at);
    end
    total++;
    if (o2_sel !== 1'(want)) begin bad++; $display("FAIL legacy sel: got %0d want %0d", o2_sel, want); end
    total++;
    if (o2_cx !== t_cx[want] || o2_box !== t_box[want] || o2_dir !== d[want]) begin
      bad++; $display("FAIL legacy data: got cx=%0d dir=%0d want cx=%0d dir=%0d", o2_cx, o2_dir, t_cx[want], d[want]);
    end
  endtask

  task automatic test_legacy();
    legacy_frame(2'b11, 2'b10, 0);
    legacy_frame(2'b11, 2'b11, 0);
    legacy_frame(2'b11, 2'b01, 1);
    legacy_frame(2'b10, 2'b11, 1);
  endtask

  task automatic test_mode1();
    do_reset();
    randomize_ch();
    t_cx[0] = 12'd100; t_cy[0] = 12'd100;
    mode = 2'd2; fix_ch = 2'd0; ch_valid = 4'b0001; ch_dir = '0;
    run_frame("m1_seed");
    t_cx[1] = 12'd110; t_cy[1] = 12'd95; t_cx[3] = 12'd300; t_cy[3] = 12'd20;
    mode = 2'd1; ch_valid = 4'b1010;
    run_frame("m1_near");
    total++;
    if (o_sel !== 2'd1 || o_cx !== 12'd110) begin
      bad++; $display("FAIL m1_near_fixed: got sel=%0d cx=%0d want sel=1 cx=110", o_sel, o_cx);
    end
    t_cx[0] = 12'd120; t_cy[0] = 12'd95; t_cx[2] = 12'd100; t_cy[2] = 12'd95;
    ch_valid = 4'b0101;
    run_frame("m1_tie");
    total++;
    if (o_sel !== 2'd0) begin bad++; $display("FAIL m1_tie_fixed: got sel=%0d want 0", o_sel); end
    for (int k = 0; k < 8; k++) begin
      randomize_ch();
      ch_valid = N'($urandom); ch_dir = N'($urandom);
      run_frame("m1_rand");
    end
  endtask

  task automatic test_mode2_loss();
    do_reset();
    randomize_ch();
    mode = 2'd0; ch_valid = 4'b1111; ch_dir = 4'b1011;
    run_frame("loss_seed");
    mode = 2'd2; fix_ch = 2'd3; ch_valid = 4'b0111;
    for (int f = 1; f <= 10; f++) begin
      randomize_ch();
      run_frame("loss");
      if (f == 7) begin
        total++;
        if (o_lost !== 1'b0) begin bad++; $display("FAIL loss_f7: got lost=%0d want 0", o_lost); end
      end
      if (f == 8) begin
        total++;
        if (o_lost !== 1'b1 || {o_cx, o_cy, o_box} !== '0) begin
          bad++; $display("FAIL loss_f8: got lost=%0d cx=%0d want lost=1 cx=0", o_lost, o_cx);
        end
      end
    end
    ch_valid = 4'b1000;
    randomize_ch();
    run_frame("loss_recover");
  endtask

  task automatic test_long_line();
    bit eu;
    int pulses;
    pulses = 0;
    randomize_ch();
    mode = 2'd0; ch_valid = 4'b1111; ch_dir = $urandom_range(0, 15);
    drive_ch();
    @(posedge clk); #1;
    y = YW'(LL);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 50) y = '0;
      if (o_upd) pulses++;
    end
    ref_commit(eu);
    total++;
    if (pulses != 1) begin bad++; $display("FAIL long_line: got %0d strobes want 1", pulses); end
    total++;
    if (o_sel !== CHW'(m_sel) || o_cx !== m_cx) begin
      bad++; $display("FAIL long_line data: got sel=%0d cx=%0d want sel=%0d cx=%0d", o_sel, o_cx, m_sel, m_cx);
    end
  endtask

  task automatic test_reset_midscan();
    int pulses;
    pulses = 0;
    randomize_ch();
    mode = 2'd0; ch_valid = 4'b1111; ch_dir = 4'b0000;
    drive_ch();
    @(posedge clk); #1;
    y = YW'(LL);
    for (int c = 1; c <= N + 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin rst_n = 1'b0; y = '0; end
      if (c == 4) rst_n = 1'b1;
      if (o_upd) pulses++;
    end
    model_reset();
    total++;
    if (pulses != 0) begin bad++; $display("FAIL midscan upd_stb: got %0d strobes want 0", pulses); end
    total++;
    if ({o_cx, o_cy, o_ax, o_ay, o_dir, o_box, o_sel} !== '0 || o_lost !== 1'b1) begin
      bad++; $display("FAIL midscan outputs: got cx=%0d sel=%0d lost=%0d want 0/0/1", o_cx, o_sel, o_lost);
    end
  endtask

`ifdef SEL_HYST_EN
  task automatic test_hyst();
    do_reset();
    randomize_ch();
    mode = 2'd0; ch_valid = 4'b1111; ch_dir = 4'b1101;
    run_frame("hyst_seed");
    ch_dir = 4'b0111;
    run_frame("hyst_one");
    total++;
    if (o_sel !== 2'd1) begin bad++; $display("FAIL hyst_one: got sel=%0d want 1", o_sel); end
    ch_dir = 4'b1101;
    run_frame("hyst_back");
    ch_dir = 4'b0111;
    run_frame("hyst_two_a");
    run_frame("hyst_two_b");
    total++;
    if (o_sel !== 2'd3) begin bad++; $display("FAIL hyst_two: got sel=%0d want 3", o_sel); end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      randomize_ch();
      mode = 2'($urandom_range(0, 3));
      fix_ch = CHW'($urandom_range(0, N - 1));
      ch_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      ch_dir = N'($urandom);
      run_frame("rand");
    end
  endtask

  initial begin
    rst_n = 1'b0; y = '0; y2 = '0; mode = '0; fix_ch = '0;
    ch_valid = '0; ch_dir = '0; v2 = '0; d2 = '0;
    ch_cx = '0; ch_cy = '0; ch_ax = '0; ch_ay = '0; ch_box = '0;
    model_reset();
    test_reset();
    test_mode0();
    test_legacy();
    test_mode1();
    test_mode2_loss();
    test_long_line();
    test_reset_midscan();
`ifdef SEL_HYST_EN
    test_hyst();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/track_selector.md
Name: track_selector

Overview:
- Parametrised N-channel successor to the two-channel frame-end target selector.
- Once per video frame, at a programmable line, scans NUM_CH object-tracker result channels sequentially and picks one channel by a runtime-selectable mode.
- Latches the chosen channel's centre/angle/direction (to the RS232 reporter) and bounding-box corners (to the VGA overlay).
- Adds per-channel valid, lost-track timeout, and an update strobe.

Parameters:
- NUM_CH, 4, number of tracker channels (2..16).
- CH_W, 2, width of channel index (ceil(log2(NUM_CH)), min 1).
- CW, 12, centre coordinate width.
- PW, 10, angle / box coordinate width.
- YW, 10, line counter width.
- LATCH_LINE, 480, line number that triggers the scan.
- MISS_LIMIT, 8, consecutive empty frames before track is declared lost.

Ports:
- clk  in  1  pixel-domain clock.
- rst_n  in  1  reset, synchronous, active-low.
- current_pos_y  in  YW  current line counter.
- mode  in  2  0 = direction-priority, 1 = nearest-to-previous, 2 = fixed channel, 3 = reserved (treated as 0).
- fix_ch  in  CH_W  channel used in mode 2.
- ch_valid  in  NUM_CH  per-channel object-present flag.
- ch_dir  in  NUM_CH  per-channel rotation direction bit.
- ch_centre_x, ch_centre_y  in  NUM_CH*CW  packed; channel i at [i*CW +: CW].
- ch_angle_x, ch_angle_y  in  NUM_CH*PW  packed likewise.
- ch_box  in  NUM_CH*8*PW  packed per channel, LSB first: top x, top y, bottom x, bottom y, left x, left y, right x, right y.
- centre_pos_x_rs232, centre_pos_y_rs232  out  CW  selected centre.
- angle_x_rs232, angle_y_rs232  out  PW  selected angle.
- chieu_xoay_rs232  out  1  selected direction bit.
- box_vga  out  8*PW  selected box, same packing as one ch_box slot.
- sel_ch  out  CH_W  index of selected channel.
- track_lost  out  1  high while no valid target for MISS_LIMIT or more frames.
- upd_stb  out  1  one-cycle pulse when outputs are refreshed.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0 and track_lost = 1. FSM to IDLE; miss counter 0; "have_prev" cleared. Reset mid-scan aborts the scan with no output update.
- Trigger: in IDLE, current_pos_y == LATCH_LINE while the registered previous y != LATCH_LINE. Edge-detected, so exactly one trigger per frame even if the line lasts many cycles. Triggers outside IDLE are ignored.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
  - Entering SCAN snapshots mode and fix_ch.
  - SCAN lasts NUM_CH cycles; channel idx = 0..NUM_CH-1 is evaluated one per cycle against the running best.
  - COMMIT lasts one cycle.
  - With trigger at cycle T, outputs take new values at the edge ending cycle T+NUM_CH+1; upd_stb is high during cycle T+NUM_CH+2 only.
- Channel inputs must be stable from T to T+NUM_CH; each channel is sampled in its own scan cycle.
- Mode 0: winner is the lowest-index valid channel with ch_dir = 0. If none exists, the lowest-index valid channel. This reproduces the two-channel legacy rule for NUM_CH = 2.
- Mode 1: winner is the valid channel minimising |cx_i - cx_out| + |cy_i - cy_out|, computed in CW+1 bits unsigned with no overflow. Ties go to the lower index. If have_prev = 0, mode 0 rules apply.
- Mode 2: winner is fix_ch if ch_valid[fix_ch] = 1, else no winner. fix_ch >= NUM_CH means no winner.
- COMMIT with a winner:
  - All outputs loaded from the winner; sel_ch = winner.
  - Miss counter cleared; track_lost = 0; have_prev = 1; upd_stb pulses.
- COMMIT with no winner:
  - Outputs hold; miss counter increments, saturating at MISS_LIMIT.
  - When the counter reaches MISS_LIMIT: centre/angle/dir/box outputs clear to 0, track_lost = 1, have_prev = 0, upd_stb pulses once on that frame.
  - No pulse on other empty frames.
- Outputs never change outside COMMIT.

Optional Feature:
- Macro SEL_HYST_EN.
- When defined: with have_prev = 1, a winner different from the current sel_ch is adopted only if it wins two consecutive frames (one pending-index register plus a flag). On the first winning frame, if ch_valid[sel_ch] = 1, outputs are refreshed from sel_ch instead; otherwise the new winner is adopted immediately.
- When undefined: the winner is adopted at once and no pending register exists.

Test Plan:
- NUM_CH=4, mode 0, valid=4'b1111, dir=4'b0011 -> sel_ch=2. upd_stb high exactly at T+6. Outputs equal channel 2 data.
- NUM_CH=2, mode 0, dir=2'b10 -> channel 0 selected; dir=2'b11 -> channel 0 (lowest valid). Legacy equivalence.
- Mode 1, previous centre (100,100); ch1 at (110,95), ch3 at (300,20) -> sel_ch=1. Equal distances on ch0/ch2 -> sel_ch=0.
- Mode 2, fix_ch=3, ch_valid[3]=0 for 8 frames -> outputs hold frames 1-7, no strobe. Frame 8: outputs 0, track_lost=1, single upd_stb.
- current_pos_y held at 480 for 50 cycles -> exactly one scan. rst_n low at T+2 -> no upd_stb, outputs 0, track_lost=1.
- SEL_HYST_EN: winner switches 1->3 for one frame then back -> sel_ch stays 1. Two consecutive frames -> sel_ch=3 on the second.
